axis_vect_packer: RTL and testbench

AXIS_VECT_PACKER -- requirements
Module: axis_vect_packer

---
 rtl/arith_pckg.sv | 8 +
 rtl/axi_if_pckg.sv | 19 +
 rtl/axis_vect_packer.sv | 165 ++++++++++++++++
 tb/tb_axis_vect_packer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pckg.sv
// Arithmetic sizing shared across the datapath.
// The packed vector width is derived from these two values.
package arith_pckg;

  localparam int C_VECT_SIZE         = 8;
  localparam int C_EXT_DATA_WORD_WDT = 16;

endpackage

// File: rtl/axi_if_pckg.sv
// AXI-stream packer types: FSM state encoding and the beats-per-vector ratio
// for the default bus widths, plus a helper for non-default widths.
package axi_if_pckg;

  typedef enum logic [1:0] {
    PACK_IDLE,
    PACK_RUN,
    PACK_DRAIN
  } pack_state_t;

  localparam int C_S_TDATA_WDT_DFLT = 64;
  localparam int BPV = (arith_pckg::C_VECT_SIZE * arith_pckg::C_EXT_DATA_WORD_WDT)
                       / C_S_TDATA_WDT_DFLT;

  function automatic int calc_bpv(input int vect_wdt, input int tdata_wdt);
    return vect_wdt / tdata_wdt;
  endfunction

endpackage

// File: rtl/axis_vect_packer.sv
// Packs AXI-stream beats into wide vectors (beat 0 in the LSBs) behind a
// single-entry output register. Optional macro AXIS_PACK_KEEP_MASK_EN zeroes bytes with TKEEP=0.
module axis_vect_packer
  import arith_pckg::*;
  import axi_if_pckg::*;
#(
  parameter int C_S_TDATA_WDT = 64,
  parameter int C_VECT_WDT    = C_VECT_SIZE * C_EXT_DATA_WORD_WDT,
  parameter int C_CNT_WDT     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [C_CNT_WDT-1:0]       cfg_vect_cnt,
  input  logic [C_S_TDATA_WDT-1:0]   S_AXIS_TDATA,
  input  logic [C_S_TDATA_WDT/8-1:0] S_AXIS_TKEEP,
  input  logic                       S_AXIS_TLAST,
  input  logic                       S_AXIS_TVALID,
  output logic                       S_AXIS_TREADY,
  output logic [C_VECT_WDT-1:0]      vect_data,
  output logic                       vect_val,
  output logic                       vect_last,
  input  logic                       vect_rdy,
  output logic                       done,
  output logic                       err_early_last,
  output logic                       err_no_last
);

  localparam int BEATS = calc_bpv(C_VECT_WDT, C_S_TDATA_WDT);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  pack_state_t            state, state_nxt;
  logic [BCW-1:0]         beat_cnt;
  logic [C_CNT_WDT-1:0]   vect_cnt;
  logic [C_CNT_WDT-1:0]   cfg_cnt;
  logic [C_VECT_WDT-1:0]  acc;
  logic [C_VECT_WDT-1:0]  vect_nxt;
  logic [C_S_TDATA_WDT-1:0] beat_data;
  logic                   at_last_beat;
  logic                   cnt_final;
  logic                   out_stall;
  logic                   beat_acc;
  logic                   vect_cmpl;
  logic                   final_beat;
  logic                   start_acc;

`ifdef AXIS_PACK_KEEP_MASK_EN
  always_comb begin
    beat_data = S_AXIS_TDATA;
    for (int b = 0; b < C_S_TDATA_WDT/8; b++) begin
      if (!S_AXIS_TKEEP[b]) begin
        beat_data[b*8 +: 8] = 8'h00;
      end
    end
  end
`else
  logic unused_keep;
  assign unused_keep = ^S_AXIS_TKEEP;
  assign beat_data   = S_AXIS_TDATA;
`endif

  assign start_acc    = (state == PACK_IDLE) && start;
  assign at_last_beat = (beat_cnt == LAST_BEAT);
  assign cnt_final    = (vect_cnt == cfg_cnt - 1'b1);
  assign out_stall    = vect_val && !vect_rdy;

  // A beat that would complete a vector must wait while the output register is
  // held; an early TLAST completes a vector too, so it is stalled the same way.
  assign S_AXIS_TREADY = (state == PACK_RUN) && !(out_stall && (at_last_beat || S_AXIS_TLAST));
  assign beat_acc      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign vect_cmpl     = beat_acc && (at_last_beat || S_AXIS_TLAST);
  assign final_beat    = beat_acc && (S_AXIS_TLAST || (at_last_beat && cnt_final));

  // acc is cleared per vector, so slices above the current beat are already zero padding.
  always_comb begin
    vect_nxt = acc;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_cnt == BCW'(i)) begin
        vect_nxt[i*C_S_TDATA_WDT +: C_S_TDATA_WDT] = beat_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      PACK_IDLE: begin
        if (start) begin
          state_nxt = (cfg_vect_cnt == '0) ? PACK_DRAIN : PACK_RUN;
        end
      end
      PACK_RUN: begin
        if (final_beat) begin
          state_nxt = PACK_DRAIN;
        end
      end
      PACK_DRAIN: begin
        if (!vect_val) begin
          done      = 1'b1;
          state_nxt = PACK_IDLE;
        end
      end
      default: state_nxt = PACK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PACK_IDLE;
      beat_cnt <= '0;
      vect_cnt <= '0;
      cfg_cnt  <= '0;
      acc      <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        cfg_cnt  <= cfg_vect_cnt;
        beat_cnt <= '0;
        vect_cnt <= '0;
        acc      <= '0;
      end else if (beat_acc) begin
        if (vect_cmpl) begin
          beat_cnt <= '0;
          vect_cnt <= vect_cnt + 1'b1;
          acc      <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          acc      <= vect_nxt;
        end
      end
    end
  end

  // Loading and draining in the same cycle keeps vect_val high with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vect_val  <= 1'b0;
      vect_last <= 1'b0;
      vect_data <= '0;
    end else if (vect_cmpl) begin
      vect_val  <= 1'b1;
      vect_last <= final_beat;
      vect_data <= vect_nxt;
    end else if (vect_rdy) begin
      vect_val  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      err_early_last <= 1'b0;
      err_no_last    <= 1'b0;
    end else if (final_beat) begin
      if (S_AXIS_TLAST && !cnt_final) begin
        err_early_last <= 1'b1;
      end
      if (!S_AXIS_TLAST && at_last_beat && cnt_final) begin
        err_no_last <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_vect_packer.sv
// Directed self-checking bench for axis_vect_packer with default widths
// (64-bit beats, 128-bit vectors, two beats per vector).
module tb_axis_vect_packer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [15:0]  cfg_vect_cnt;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic         s_tlast;
  logic         s_tvalid;
  logic         s_tready;
  logic [127:0] vect_data;
  logic         vect_val;
  logic         vect_last;
  logic         vect_rdy;
  logic         done;
  logic         err_early_last;
  logic         err_no_last;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [127:0] got_data[$];
  logic         got_last[$];

  axis_vect_packer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_vect_cnt  (cfg_vect_cnt),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TKEEP  (s_tkeep),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .vect_data     (vect_data),
    .vect_val      (vect_val),
    .vect_last     (vect_last),
    .vect_rdy      (vect_rdy),
    .done          (done),
    .err_early_last(err_early_last),
    .err_no_last   (err_no_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every vector handshake and done pulse mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (vect_val && vect_rdy) begin
      got_data.push_back(vect_data);
      got_last.push_back(vect_last);
    end
    if (done) done_cnt++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_log();
    got_data.delete();
    got_last.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    cfg_vect_cnt = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, input logic [7:0] k,
                           output int stalls);
    int waited;
    bit got;
    waited = 0;
    got = 0;
    stalls = 0;
    s_tdata = d;
    s_tlast = l;
    s_tkeep = k;
    s_tvalid = 1'b1;
    while (!got && waited < 200) begin
      @(negedge clk);
      if (s_tready) got = 1;
      else stalls++;
      @(posedge clk);
      #1;
      waited++;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL beat_accept data=%0h accepted=0 required=1", d);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (s_tready !== 1'b0) begin bad++; $display("[TB] FAIL reset_tready got=%b exp=0", s_tready); end
    total++;
    if (vect_val !== 1'b0) begin bad++; $display("[TB] FAIL reset_vect_val got=%b exp=0", vect_val); end
    total++;
    if (vect_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_vect_last got=%b exp=0", vect_last); end
    total++;
    if (vect_data !== 128'd0) begin bad++; $display("[TB] FAIL reset_vect_data got=%h exp=0", vect_data); end
    total++;
    if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    total++;
    if ({err_early_last, err_no_last} !== 2'b00) begin
      bad++; $display("[TB] FAIL reset_errs got=%b%b exp=00", err_early_last, err_no_last);
    end
  endtask

  task automatic test_basic();
    logic [127:0] exp_d[3];
    logic         exp_l[3];
    int st;
    exp_d = '{{64'd2, 64'd1}, {64'd4, 64'd3}, {64'd6, 64'd5}};
    exp_l = '{1'b0, 1'b0, 1'b1};
    clear_log();
    vect_rdy = 1'b1;
    do_start(16'd3);
    for (int i = 1; i <= 6; i++) send_beat(64'(i), (i == 6), 8'hFF, st);
    wait_done();
    total++;
    if (got_data.size() != 3) begin bad++; $display("[TB] FAIL basic_count got=%0d exp=3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        bad++;
        $display("[TB] FAIL basic_vect%0d got=%h/%b exp=%h/%b", i,
                 (i < got_data.size()) ? got_data[i] : 128'hx,
                 (i < got_last.size()) ? got_last[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("[TB] FAIL basic_done got=%0d exp=1", done_cnt); end
    total++;
    if ({err_early_last, err_no_last} !== 2'b00) begin
      bad++; $display("[TB] FAIL basic_errs got=%b%b exp=00", err_early_last, err_no_last);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp_d[3];
    logic         exp_l[3];
    int st;
    int stall4;
    exp_d = '{{64'd2, 64'd1}, {64'd4, 64'd3}, {64'd6, 64'd5}};
    exp_l = '{1'b0, 1'b0, 1'b1};
    stall4 = 0;
    clear_log();
    vect_rdy = 1'b0;
    fork
      begin
        repeat (10) @(posedge clk);
        #1 vect_rdy = 1'b1;
      end
      begin
        do_start(16'd3);
        for (int i = 1; i <= 6; i++) begin
          send_beat(64'(i), (i == 6), 8'hFF, st);
          if (i == 4) stall4 = st;
        end
      end
    join
    wait_done();
    total++;
    if (stall4 == 0) begin bad++; $display("[TB] FAIL bp_tready_stall got=%0d stall cycles exp=>0", stall4); end
    total++;
    if (got_data.size() != 3) begin bad++; $display("[TB] FAIL bp_count got=%0d exp=3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        bad++;
        $display("[TB] FAIL bp_vect%0d got=%h/%b exp=%h/%b", i,
                 (i < got_data.size()) ? got_data[i] : 128'hx,
                 (i < got_last.size()) ? got_last[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("[TB] FAIL bp_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_early_last();
    logic [127:0] exp_d[2];
    logic         exp_l[2];
    int st;
    exp_d = '{{64'd2, 64'd1}, {64'd0, 64'd3}};
    exp_l = '{1'b0, 1'b1};
    clear_log();
    vect_rdy = 1'b1;
    do_start(16'd3);
    for (int i = 1; i <= 3; i++) send_beat(64'(i), (i == 3), 8'hFF, st);
    wait_done();
    total++;
    if (got_data.size() != 2) begin bad++; $display("[TB] FAIL early_count got=%0d exp=2", got_data.size()); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        bad++;
        $display("[TB] FAIL early_vect%0d got=%h/%b exp=%h/%b", i,
                 (i < got_data.size()) ? got_data[i] : 128'hx,
                 (i < got_last.size()) ? got_last[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    total++;
    if ({err_early_last, err_no_last} !== 2'b10) begin
      bad++; $display("[TB] FAIL early_errs got=%b%b exp=10", err_early_last, err_no_last);
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("[TB] FAIL early_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_no_last();
    logic [127:0] exp_d[2];
    logic         exp_l[2];
    int st;
    int rdy_seen;
    exp_d = '{{64'd2, 64'd1}, {64'd4, 64'd3}};
    exp_l = '{1'b0, 1'b1};
    rdy_seen = 0;
    clear_log();
    vect_rdy = 1'b1;
    do_start(16'd2);
    for (int i = 1; i <= 4; i++) send_beat(64'(i), 1'b0, 8'hFF, st);
    wait_done();
    s_tdata = 64'd5;
    s_tvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (s_tready !== 1'b0) rdy_seen++;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    total++;
    if (rdy_seen != 0) begin bad++; $display("[TB] FAIL nolast_tready got=%0d ready cycles exp=0", rdy_seen); end
    total++;
    if (got_data.size() != 2) begin bad++; $display("[TB] FAIL nolast_count got=%0d exp=2", got_data.size()); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        bad++;
        $display("[TB] FAIL nolast_vect%0d got=%h/%b exp=%h/%b", i,
                 (i < got_data.size()) ? got_data[i] : 128'hx,
                 (i < got_last.size()) ? got_last[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    total++;
    if ({err_early_last, err_no_last} !== 2'b01) begin
      bad++; $display("[TB] FAIL nolast_errs got=%b%b exp=01", err_early_last, err_no_last);
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("[TB] FAIL nolast_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_cfg_zero();
    clear_log();
    vect_rdy = 1'b1;
    s_tdata = 64'd9;
    s_tvalid = 1'b1;
    do_start(16'd0);
    total++;
    if (done !== 1'b1) begin bad++; $display("[TB] FAIL zero_done_pulse got=%b exp=1", done); end
    total++;
    if (s_tready !== 1'b0) begin bad++; $display("[TB] FAIL zero_tready got=%b exp=0", s_tready); end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("[TB] FAIL zero_done_width got=%b exp=0", done); end
    s_tvalid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (got_data.size() != 0) begin bad++; $display("[TB] FAIL zero_vects got=%0d exp=0", got_data.size()); end
    total++;
    if ({err_early_last, err_no_last} !== 2'b00) begin
      bad++; $display("[TB] FAIL zero_errs got=%b%b exp=00", err_early_last, err_no_last);
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] exp_d[2];
    logic         exp_l[2];
    int st;
    exp_d = '{{64'd2, 64'd1}, {64'd4, 64'd3}};
    exp_l = '{1'b0, 1'b1};
    clear_log();
    vect_rdy = 1'b0;
    do_start(16'd3);
    for (int i = 1; i <= 3; i++) send_beat(64'(i), 1'b0, 8'hFF, st);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if ({s_tready, vect_val, vect_last, done, err_early_last, err_no_last} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL midrst_ctrl got=%b%b%b%b%b%b exp=000000", s_tready, vect_val,
               vect_last, done, err_early_last, err_no_last);
    end
    total++;
    if (vect_data !== 128'd0) begin bad++; $display("[TB] FAIL midrst_data got=%h exp=0", vect_data); end
    vect_rdy = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (got_data.size() != 0) begin bad++; $display("[TB] FAIL midrst_stale got=%0d vectors exp=0", got_data.size()); end
    clear_log();
    do_start(16'd2);
    for (int i = 1; i <= 4; i++) send_beat(64'(i), (i == 4), 8'hFF, st);
    wait_done();
    total++;
    if (got_data.size() != 2) begin bad++; $display("[TB] FAIL midrst_count got=%0d exp=2", got_data.size()); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= got_data.size() || got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
        bad++;
        $display("[TB] FAIL midrst_vect%0d got=%h/%b exp=%h/%b", i,
                 (i < got_data.size()) ? got_data[i] : 128'hx,
                 (i < got_last.size()) ? got_last[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    total++;
    if (done_cnt != 1 || {err_early_last, err_no_last} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL midrst_done_errs got=%0d/%b%b exp=1/00", done_cnt, err_early_last, err_no_last);
    end
  endtask

  task automatic test_keep();
    logic [127:0] exp_v;
    int st;
`ifdef AXIS_PACK_KEEP_MASK_EN
    exp_v = {64'd0, 64'h0000_0000_FFFF_FFFF};
`else
    exp_v = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
`endif
    clear_log();
    vect_rdy = 1'b1;
    do_start(16'd1);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h0F, st);
    wait_done();
    total++;
    if (got_data.size() != 1 || got_data[0] !== exp_v || got_last[0] !== 1'b1) begin
      bad++;
      $display("[TB] FAIL keep_vect got=%h/%b count=%0d exp=%h/1",
               (got_data.size() > 0) ? got_data[0] : 128'hx,
               (got_last.size() > 0) ? got_last[0] : 1'bx, got_data.size(), exp_v);
    end
    total++;
    if ({err_early_last, err_no_last} !== 2'b00 || done_cnt != 1) begin
      bad++;
      $display("[TB] FAIL keep_errs_done got=%b%b/%0d exp=00/1", err_early_last, err_no_last, done_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_vect_cnt = 16'd0;
    s_tdata = 64'd0;
    s_tkeep = 8'hFF;
    s_tlast = 1'b0;
    s_tvalid = 1'b0;
    vect_rdy = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_early_last();
    test_no_last();
    test_cfg_zero();
    test_mid_reset();
    test_keep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
